// File: rtl/duck_link_pkg.sv
// Shared definitions for the Duck Hunt board-to-board link (rx deframer and tx framer).
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
//
// Contents:
//   link_state_t      - deframer FSM states (HUNT, PAYLOAD, CHECK)
//   PAYLOAD_LEN       - payload bytes between the sync byte and the checksum
//   COORD_W           - cursor coordinate width
//   DEFAULT_SYNC_BYTE - header byte that opens every packet
//   coord_join()      - builds a coordinate from its high nibble and low byte
package duck_link_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } link_state_t;

    localparam int         PAYLOAD_LEN       = 5;
    localparam int         COORD_W           = 12;
    localparam int         IDX_W             = 3;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Coordinates travel as HI (only the low nibble is meaningful) then LO.
    function automatic logic [COORD_W-1:0] coord_join(input logic [3:0] hi,
                                                      input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/link_watchdog.sv
// Idle-cycle timeout counter: flags the cycle in which the idle count reaches TIMEOUT.
// Latency: expired is combinational from the registered count; the count clears on the edge after kick.
// Backpressure: none; kick and tick are sampled every cycle.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   kick       - clears the idle count (takes priority over tick)
//   tick       - advances the idle count when kick is low
//   expired    - high in the cycle whose edge brings the count to TIMEOUT
module link_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic tick,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;

    // Fires once, on the tick that would take the count to TIMEOUT. A kick in
    // the same cycle wins, so a byte or good packet arriving on the deadline
    // never times out.
    assign expired = tick && !kick && (r_cnt == LAST);

    // The count parks at TIMEOUT so expiry is a single-cycle event until the
    // next kick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (kick) begin
            r_cnt <= '0;
        end else if (tick && (r_cnt != FULL)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/duck_link_rx.sv
// Receive deframer for the Duck Hunt link: hunts sync, collects payload, publishes remote cursor/shot.
// Latency: fields and pkt_valid update on the edge after the packet's final byte is accepted.
// Backpressure: none; every rx_valid cycle is consumed as one byte.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   rx_data, rx_valid   - byte stream from the UART receive FIFO
//   remote_x, remote_y  - last good remote cursor position
//   remote_shot         - last good remote trigger flag
//   pkt_valid           - one-cycle pulse on the edge the fields were refreshed
//   link_up             - a good packet arrived within the last LINK_TIMEOUT cycles
//   err_cnt             - saturating count of rejected packets
//
// Build option DUCK_LINK_CHECKSUM_EN: when defined, a CHK byte (sum of the five
// payload bytes mod 256) follows FLAGS and is verified; when undefined, FLAGS
// completes the packet and err_cnt counts byte timeouts only.
module duck_link_rx
    import duck_link_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         BYTE_TIMEOUT = 50_000,
    parameter int         LINK_TIMEOUT = 6_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [COORD_W-1:0] remote_x,
    output logic [COORD_W-1:0] remote_y,
    output logic               remote_shot,
    output logic               pkt_valid,
    output logic               link_up,
    output logic [7:0]         err_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

    link_state_t        r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_x_hi;
    logic [7:0]         r_x_lo;
    logic [3:0]         r_y_hi;
    logic [7:0]         r_y_lo;
`ifdef DUCK_LINK_CHECKSUM_EN
    logic               r_shot_sh;
    logic [7:0]         r_sum;
`endif

    logic [COORD_W-1:0] r_remote_x;
    logic [COORD_W-1:0] r_remote_y;
    logic               r_remote_shot;
    logic               r_pkt_valid;
    logic               r_link_up;
    logic [7:0]         r_err_cnt;

    link_state_t        w_state_nxt;
    logic               w_good;
    logic               w_reject;
    logic               w_byte_exp;
    logic               w_link_exp;
    logic               w_sync_hit;

    assign w_sync_hit = rx_valid && (rx_data == SYNC_BYTE);

    // Inter-byte timeout. It runs in every state, but only PAYLOAD/CHECK act
    // on it; entering a packet always kicks it via the sync byte.
    link_watchdog #(
        .TIMEOUT (BYTE_TIMEOUT)
    ) u_byte_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .kick    (rx_valid),
        .tick    (1'b1),
        .expired (w_byte_exp)
    );

    // Link-health timeout, restarted by every accepted packet.
    link_watchdog #(
        .TIMEOUT (LINK_TIMEOUT)
    ) u_link_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .kick    (w_good),
        .tick    (1'b1),
        .expired (w_link_exp)
    );

    // Next-state and packet verdict. A byte and a timeout cannot coincide
    // (a byte kicks the watchdog), so w_good and w_reject are exclusive and
    // each rejected packet is counted once.
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_sync_hit) begin
                    w_state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    // Sync-valued bytes are plain data here: no resync.
                    if (r_idx == LAST_IDX) begin
`ifdef DUCK_LINK_CHECKSUM_EN
                        w_state_nxt = CHECK;
`else
                        w_state_nxt = HUNT;
                        w_good      = 1'b1;
`endif
                    end
                end else if (w_byte_exp) begin
                    w_state_nxt = HUNT;
                    w_reject    = 1'b1;
                end
            end
`ifdef DUCK_LINK_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    w_state_nxt = HUNT;
                    if (rx_data == r_sum) begin
                        w_good = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end else if (w_byte_exp) begin
                    w_state_nxt = HUNT;
                    w_reject    = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_idx         <= '0;
            r_x_hi        <= '0;
            r_x_lo        <= '0;
            r_y_hi        <= '0;
            r_y_lo        <= '0;
`ifdef DUCK_LINK_CHECKSUM_EN
            r_shot_sh     <= 1'b0;
            r_sum         <= '0;
`endif
            r_remote_x    <= '0;
            r_remote_y    <= '0;
            r_remote_shot <= 1'b0;
            r_pkt_valid   <= 1'b0;
            r_link_up     <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pkt_valid <= w_good;

            // Shadow capture: payload bytes land here and only reach the
            // outputs once the whole packet is accepted.
            if ((r_state == HUNT) && w_sync_hit) begin
                r_idx <= '0;
`ifdef DUCK_LINK_CHECKSUM_EN
                r_sum <= '0;
`endif
            end else if ((r_state == PAYLOAD) && rx_valid) begin
                r_idx <= r_idx + IDX_W'(1);
`ifdef DUCK_LINK_CHECKSUM_EN
                r_sum <= r_sum + rx_data;
`endif
                case (r_idx)
                    3'd0:    r_x_hi    <= rx_data[3:0];
                    3'd1:    r_x_lo    <= rx_data;
                    3'd2:    r_y_hi    <= rx_data[3:0];
                    3'd3:    r_y_lo    <= rx_data;
`ifdef DUCK_LINK_CHECKSUM_EN
                    3'd4:    r_shot_sh <= rx_data[0];
`endif
                    default: ;
                endcase
            end

            if (w_good) begin
                r_remote_x <= coord_join(r_x_hi, r_x_lo);
                r_remote_y <= coord_join(r_y_hi, r_y_lo);
`ifdef DUCK_LINK_CHECKSUM_EN
                r_remote_shot <= r_shot_sh;
`else
                // FLAGS is the closing byte, so it is taken straight off the bus.
                r_remote_shot <= rx_data[0];
`endif
            end

            if (w_reject && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            // A good packet on the expiry cycle kicks the watchdog, so set wins.
            if (w_good) begin
                r_link_up <= 1'b1;
            end else if (w_link_exp) begin
                r_link_up <= 1'b0;
            end
        end
    end

    assign remote_x    = r_remote_x;
    assign remote_y    = r_remote_y;
    assign remote_shot = r_remote_shot;
    assign pkt_valid   = r_pkt_valid;
    assign link_up     = r_link_up;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_duck_link_rx.sv
// Self-checking bench for duck_link_rx: directed scenarios plus randomized traffic
// compared against a byte-stream reference model. Works with or without
// DUCK_LINK_CHECKSUM_EN.
module tb_duck_link_rx;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         BYTE_TO = 16;
    localparam int         LINK_TO = 300;
`ifdef DUCK_LINK_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    // Bytes after the sync byte that make up one packet.
    localparam int BODY = CHK_EN ? 6 : 5;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] remote_x;
    logic [11:0] remote_y;
    logic        remote_shot;
    logic        pkt_valid;
    logic        link_up;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    duck_link_rx #(
        .SYNC_BYTE    (SYNC),
        .BYTE_TIMEOUT (BYTE_TO),
        .LINK_TIMEOUT (LINK_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .remote_x    (remote_x),
        .remote_y    (remote_y),
        .remote_shot (remote_shot),
        .pkt_valid   (pkt_valid),
        .link_up     (link_up),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_in;
    logic [7:0]  m_q[$];
    int          m_idle;
    int          m_lcnt;
    logic [11:0] m_x;
    logic [11:0] m_y;
    logic        m_shot;
    logic        m_pv;
    logic        m_link;
    int          m_err;
    int          m_pv_cnt = 0;

    int pv_obs = 0;
    int pv_bad = 0;
    logic [7:0] seq[$];

    function automatic void model_reset();
        m_in = 0; m_q.delete(); m_idle = 0; m_lcnt = 0;
        m_x = '0; m_y = '0; m_shot = 1'b0; m_pv = 1'b0; m_link = 1'b0; m_err = 0;
    endfunction

    function automatic void model_edge(input logic v, input logic [7:0] d);
        bit good = 0;
        int sum = 0;
        m_pv = 1'b0;
        if (v) begin
            m_idle = 0;
            if (!m_in) begin
                if (d == SYNC) begin
                    m_in = 1;
                    m_q.delete();
                end
            end else begin
                m_q.push_back(d);
                if (m_q.size() == BODY) begin
                    m_in = 0;
                    for (int i = 0; i < 5; i++) sum += m_q[i];
                    if (!CHK_EN || ((sum % 256) == m_q[5])) good = 1;
                    else if (m_err < 255) m_err++;
                end
            end
        end else begin
            m_idle++;
            if (m_in && m_idle == BYTE_TO) begin
                m_in = 0;
                if (m_err < 255) m_err++;
            end
        end
        if (good) begin
            m_x = {m_q[0][3:0], m_q[1]};
            m_y = {m_q[2][3:0], m_q[3]};
            m_shot = m_q[4][0];
            m_pv = 1'b1;
            m_link = 1'b1;
            m_lcnt = 0;
            m_pv_cnt++;
        end else begin
            m_lcnt++;
            if (m_lcnt == LINK_TO) m_link = 1'b0;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called #1 after a rising edge; drives one cycle and samples #1 after the next edge.
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        if (pkt_valid === 1'b1) pv_obs++;
        if (pkt_valid !== m_pv) pv_bad++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic send_seq();
        for (int i = 0; i < seq.size(); i++) step(1'b1, seq[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic int pick_gap();
        int r = $urandom_range(0, 19);
        if (r < 14) return 0;
        if (r < 18) return $urandom_range(1, 3);
        if (r == 18) return BYTE_TO - 1;
        return BYTE_TO;
    endfunction

    task automatic send_pkt(input logic [11:0] x, input logic [11:0] y, input logic shot,
                            input bit corrupt, input bit gaps);
        logic [7:0] b[6];
        logic [7:0] sum;
        b[0] = {4'($urandom_range(0, 15)), x[11:8]};
        b[1] = x[7:0];
        b[2] = {4'($urandom_range(0, 15)), y[11:8]};
        b[3] = y[7:0];
        b[4] = {7'($urandom_range(0, 127)), shot};
        sum  = b[0] + b[1] + b[2] + b[3] + b[4];
        b[5] = corrupt ? (sum + 8'd1 + 8'($urandom_range(0, 254))) : sum;
        step(1'b1, SYNC);
        for (int i = 0; i < BODY; i++) begin
            if (gaps) idle(pick_gap());
            step(1'b1, b[i]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (remote_x !== 12'h000) begin errors++; $display("FAIL reset_x: got %h want 000", remote_x); end
        checks++; if (remote_y !== 12'h000) begin errors++; $display("FAIL reset_y: got %h want 000", remote_y); end
        checks++; if (remote_shot !== 1'b0) begin errors++; $display("FAIL reset_shot: got %b want 0", remote_shot); end
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pv: got %b want 0", pkt_valid); end
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link: got %b want 0", link_up); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_good_packet();
        logic [7:0] last;
        seq = '{8'hA5, 8'h01, 8'h23, 8'h02, 8'h5A, 8'h01};
        if (CHK_EN) seq.push_back(8'h81);
        last = seq.pop_back();
        send_seq();
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL good_pv_early: got %b want 0", pkt_valid); end
        step(1'b1, last);
        checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL good_pv: got %b want 1", pkt_valid); end
        checks++; if (remote_x !== 12'h123) begin errors++; $display("FAIL good_x: got %h want 123", remote_x); end
        checks++; if (remote_y !== 12'h25A) begin errors++; $display("FAIL good_y: got %h want 25a", remote_y); end
        checks++; if (remote_shot !== 1'b1) begin errors++; $display("FAIL good_shot: got %b want 1", remote_shot); end
        checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL good_link: got %b want 1", link_up); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL good_err: got %0d want 0", err_cnt); end
        step(1'b0, 8'h00);
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL good_pv_width: got %b want 0", pkt_valid); end
    endtask

`ifdef DUCK_LINK_CHECKSUM_EN
    task automatic test_bad_checksum();
        int pv0 = pv_obs;
        // Correct CHK would be 0x0E.
        seq = '{8'hA5, 8'h07, 8'h77, 8'h08, 8'h88, 8'h00, 8'h0F};
        send_seq();
        idle(2);
        checks++; if (pv_obs !== pv0) begin errors++; $display("FAIL badchk_pv: got %0d pulses want 0", pv_obs - pv0); end
        checks++; if (remote_x !== 12'h123) begin errors++; $display("FAIL badchk_x: got %h want 123", remote_x); end
        checks++; if (remote_y !== 12'h25A) begin errors++; $display("FAIL badchk_y: got %h want 25a", remote_y); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL badchk_err: got %0d want 1", err_cnt); end
        seq = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h1E};
        send_seq();
        checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL badchk_next_pv: got %b want 1", pkt_valid); end
        checks++; if (remote_x !== 12'hFFF) begin errors++; $display("FAIL badchk_next_x: got %h want fff", remote_x); end
        checks++; if (remote_y !== 12'h010) begin errors++; $display("FAIL badchk_next_y: got %h want 010", remote_y); end
        checks++; if (remote_shot !== 1'b0) begin errors++; $display("FAIL badchk_next_shot: got %b want 0", remote_shot); end
    endtask
`endif

    task automatic test_sync_in_payload();
        seq = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        if (CHK_EN) seq.push_back(8'hA5);
        send_seq();
        checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL sync_pv: got %b want 1", pkt_valid); end
        checks++; if (remote_x !== 12'h500) begin errors++; $display("FAIL sync_x: got %h want 500", remote_x); end
        checks++; if (remote_y !== 12'h000) begin errors++; $display("FAIL sync_y: got %h want 000", remote_y); end
        checks++; if (remote_shot !== 1'b0) begin errors++; $display("FAIL sync_shot: got %b want 0", remote_shot); end
        idle(1);
    endtask

    task automatic test_stall();
        int e0 = m_err;
        seq = '{8'hA5, 8'h01, 8'h23};
        send_seq();
        idle(BYTE_TO - 1);
        checks++; if (err_cnt !== 8'(e0)) begin errors++; $display("FAIL stall_early: got %0d want %0d", err_cnt, e0); end
        idle(1);
        checks++; if (err_cnt !== 8'(e0 + 1)) begin errors++; $display("FAIL stall_abort: got %0d want %0d", err_cnt, e0 + 1); end
        send_pkt(12'h3C4, 12'h0F1, 1'b1, 1'b0, 1'b0);
        checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL stall_next_pv: got %b want 1", pkt_valid); end
        checks++; if (remote_x !== 12'h3C4) begin errors++; $display("FAIL stall_next_x: got %h want 3c4", remote_x); end
        checks++; if (remote_y !== 12'h0F1) begin errors++; $display("FAIL stall_next_y: got %h want 0f1", remote_y); end
        // A byte landing exactly in the timeout cycle keeps the packet alive.
        step(1'b1, 8'hA5);
        step(1'b1, 8'h01);
        idle(BYTE_TO - 1);
        seq = '{8'h23, 8'h02, 8'h5A, 8'h01};
        if (CHK_EN) seq.push_back(8'h81);
        send_seq();
        checks++; if (err_cnt !== 8'(e0 + 1)) begin errors++; $display("FAIL stall_bytewins_err: got %0d want %0d", err_cnt, e0 + 1); end
        checks++; if (remote_x !== 12'h123) begin errors++; $display("FAIL stall_bytewins_x: got %h want 123", remote_x); end
    endtask

    task automatic test_link_loss();
        send_pkt(12'h0AB, 12'h0CD, 1'b0, 1'b0, 1'b0);
        idle(LINK_TO - 1);
        checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL link_hold: got %b want 1", link_up); end
        idle(1);
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL link_drop: got %b want 0", link_up); end
        checks++; if (remote_x !== 12'h0AB) begin errors++; $display("FAIL link_fields_hold: got %h want 0ab", remote_x); end
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 300; i++) begin
            if (CHK_EN) begin
                send_pkt(12'($urandom), 12'($urandom), 1'b0, 1'b1, 1'b0);
            end else begin
                step(1'b1, SYNC);
                idle(BYTE_TO);
            end
        end
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_sat: got %0d want 255", err_cnt); end
        checks++; if (m_err !== 255) begin errors++; $display("FAIL err_sat_model: got %0d want 255", m_err); end
    endtask

    task automatic test_reset_mid_packet();
        int pv0;
        seq = '{8'hA5, 8'h01, 8'h23};
        send_seq();
        pv0 = pv_obs;
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        checks++; if ({remote_x, remote_y, remote_shot, pkt_valid, link_up} !== 27'd0)
            begin errors++; $display("FAIL rstmid_outputs: got %h want 0", {remote_x, remote_y, remote_shot, pkt_valid, link_up}); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_err: got %0d want 0", err_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(3);
        checks++; if (pv_obs !== pv0) begin errors++; $display("FAIL rstmid_pv: got %0d pulses want 0", pv_obs - pv0); end
        seq = '{8'hA5, 8'h01, 8'h23, 8'h02, 8'h5A, 8'h01};
        if (CHK_EN) seq.push_back(8'h81);
        send_seq();
        checks++; if (remote_x !== 12'h123) begin errors++; $display("FAIL rstmid_next_x: got %h want 123", remote_x); end
        checks++; if (remote_y !== 12'h25A) begin errors++; $display("FAIL rstmid_next_y: got %h want 25a", remote_y); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_next_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 40; p++) begin
            int nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) step(1'b1, 8'($urandom));
            send_pkt(12'($urandom), 12'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0), 1'b1);
            idle($urandom_range(0, 3));
            checks++; if ({remote_x, remote_y, remote_shot} !== {m_x, m_y, m_shot})
                begin errors++; $display("FAIL rand_fields pkt %0d: got %h/%h/%b want %h/%h/%b", p, remote_x, remote_y, remote_shot, m_x, m_y, m_shot); end
            checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL rand_err pkt %0d: got %0d want %0d", p, err_cnt, m_err); end
        end
        idle(BYTE_TO + 1);
        checks++; if (link_up !== m_link) begin errors++; $display("FAIL rand_link: got %b want %b", link_up, m_link); end
        checks++; if (pv_obs !== m_pv_cnt) begin errors++; $display("FAIL pv_count: got %0d want %0d", pv_obs, m_pv_cnt); end
        checks++; if (pv_bad !== 0) begin errors++; $display("FAIL pv_timing: got %0d cycles off want 0", pv_bad); end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        #1;
        test_reset();
        test_good_packet();
`ifdef DUCK_LINK_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_sync_in_payload();
        test_stall();
        test_link_loss();
        test_err_saturation();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
